// File: rtl/pic_bus_sequencer.sv
// Drives an 8259-style PIC bus: ICW/OCW init writes, INTA handshake, EOI writes.
// Latency: start -> first write SETUP next clk; each bus cycle STROBE_CYCLES+2 clks.
// Backpressure: start ignored while busy; eoi_req outside READY held in one pending flag.
// Optional status read (OCW3 + RD cycle) enabled by PIC_SEQ_STATUS_READ_EN.
module pic_bus_sequencer #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       init_done,
    input  logic       cfg_ltim,
    input  logic       cfg_sngl,
    input  logic       cfg_ic4,
    input  logic       cfg_aeoi,
    input  logic [4:0] cfg_vec_base,
    input  logic [7:0] cfg_icw3,
    input  logic [7:0] cfg_mask,
    output logic       WD,
    output logic       RD,
    output logic       A0,
    output logic [7:0] dout,
    output logic       dout_en,
    input  logic [7:0] din,
    input  logic       INT,
    output logic       INTA,
    input  logic       eoi_req,
    output logic       vec_valid,
    output logic [7:0] vec
`ifdef PIC_SEQ_STATUS_READ_EN
    ,
    input  logic       stat_req,
    input  logic       stat_sel,
    output logic [7:0] stat,
    output logic       stat_valid
`endif
);

    localparam logic [3:0] SC    = 4'(STROBE_CYCLES);
    localparam logic [3:0] SC_M1 = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] SC_P1 = 4'(STROBE_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE, W_ICW1, W_ICW2, W_ICW3, W_ICW4, W_OCW1, READY,
        ACK1, ACK_GAP, ACK2, W_EOI
`ifdef PIC_SEQ_STATUS_READ_EN
        , W_OCW3, R_STAT
`endif
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] sub, sub_nxt;

    logic       ltim_q, sngl_q, ic4_q, aeoi_q;
    logic [4:0] vec_base_q;
    logic [7:0] icw3_q, mask_q;
    logic       eoi_pend;

    logic       start_acc, eoi_go, wr_last, in_strobe, ack_last;
    logic       wr_cyc, rd_cyc, a0_sel;
    logic [7:0] wr_byte;

`ifdef PIC_SEQ_STATUS_READ_EN
    logic       sel_q;
`endif

    assign start_acc = start && (state == IDLE || state == READY);
    assign eoi_go    = (eoi_pend || eoi_req) && !aeoi_q;
    assign wr_last   = (sub == SC_P1);
    assign ack_last  = (sub == SC_M1);
    assign in_strobe = (sub >= 4'd1) && (sub <= SC);
    assign busy      = (state != IDLE) && (state != READY);

    // Byte/address for the current bus cycle; everything else idles the bus.
    always_comb begin
        wr_cyc  = 1'b0;
        rd_cyc  = 1'b0;
        a0_sel  = 1'b0;
        wr_byte = 8'h00;
        case (state)
            W_ICW1: begin wr_cyc = 1'b1; wr_byte = {3'b000, 1'b1, ltim_q, 1'b0, sngl_q, ic4_q}; end
            W_ICW2: begin wr_cyc = 1'b1; a0_sel = 1'b1; wr_byte = {vec_base_q, 3'b000}; end
            W_ICW3: begin wr_cyc = 1'b1; a0_sel = 1'b1; wr_byte = icw3_q; end
            W_ICW4: begin wr_cyc = 1'b1; a0_sel = 1'b1; wr_byte = {6'b000000, aeoi_q, 1'b1}; end
            W_OCW1: begin wr_cyc = 1'b1; a0_sel = 1'b1; wr_byte = mask_q; end
            W_EOI:  begin wr_cyc = 1'b1; wr_byte = 8'h20; end
`ifdef PIC_SEQ_STATUS_READ_EN
            W_OCW3: begin wr_cyc = 1'b1; wr_byte = {6'b000010, 1'b1, sel_q}; end
            R_STAT: rd_cyc = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        WD      = !(wr_cyc && in_strobe);
        dout_en = wr_cyc;
        dout    = wr_cyc ? wr_byte : 8'h00;
        A0      = (wr_cyc || rd_cyc) ? a0_sel : 1'b0;
        INTA    = !(state == ACK1 || state == ACK2);
`ifdef PIC_SEQ_STATUS_READ_EN
        RD      = !(rd_cyc && in_strobe);
`else
        RD      = 1'b1;
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = W_ICW1;
            READY: begin
                if (start)       state_nxt = W_ICW1;
                else if (eoi_go) state_nxt = W_EOI;
                else if (INT)    state_nxt = ACK1;
`ifdef PIC_SEQ_STATUS_READ_EN
                else if (stat_req) state_nxt = W_OCW3;
`endif
            end
            W_ICW1:  if (wr_last) state_nxt = W_ICW2;
            W_ICW2:  if (wr_last) state_nxt = !sngl_q ? W_ICW3 : (ic4_q ? W_ICW4 : W_OCW1);
            W_ICW3:  if (wr_last) state_nxt = ic4_q ? W_ICW4 : W_OCW1;
            W_ICW4:  if (wr_last) state_nxt = W_OCW1;
            W_OCW1:  if (wr_last) state_nxt = READY;
            W_EOI:   if (wr_last) state_nxt = READY;
            ACK1:    if (ack_last) state_nxt = ACK_GAP;
            ACK_GAP: if (sub == 4'd1) state_nxt = ACK2;
            ACK2:    if (ack_last) state_nxt = READY;
`ifdef PIC_SEQ_STATUS_READ_EN
            W_OCW3:  if (wr_last) state_nxt = R_STAT;
            R_STAT:  if (wr_last) state_nxt = READY;
`endif
            default: state_nxt = IDLE;
        endcase
        sub_nxt = (state_nxt != state || state == IDLE || state == READY) ? 4'd0 : sub + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sub        <= 4'd0;
            init_done  <= 1'b0;
            vec        <= 8'h00;
            vec_valid  <= 1'b0;
            eoi_pend   <= 1'b0;
            ltim_q     <= 1'b0;
            sngl_q     <= 1'b0;
            ic4_q      <= 1'b0;
            aeoi_q     <= 1'b0;
            vec_base_q <= 5'd0;
            icw3_q     <= 8'h00;
            mask_q     <= 8'h00;
        end else begin
            state     <= state_nxt;
            sub       <= sub_nxt;
            vec_valid <= 1'b0;
            if (start_acc) begin
                init_done  <= 1'b0;
                ltim_q     <= cfg_ltim;
                sngl_q     <= cfg_sngl;
                ic4_q      <= cfg_ic4;
                aeoi_q     <= cfg_aeoi;
                vec_base_q <= cfg_vec_base;
                icw3_q     <= cfg_icw3;
                mask_q     <= cfg_mask;
            end
            if (state == W_OCW1 && wr_last)
                init_done <= 1'b1;
            if (state == ACK2 && ack_last) begin
                vec       <= din;
                vec_valid <= 1'b1;
            end
            // A request that arrives while one is being dispatched is kept for later.
            if (state == READY && state_nxt == W_EOI)
                eoi_pend <= 1'b0;
            else if (eoi_req && !aeoi_q)
                eoi_pend <= 1'b1;
        end
    end

`ifdef PIC_SEQ_STATUS_READ_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q      <= 1'b0;
            stat       <= 8'h00;
            stat_valid <= 1'b0;
        end else begin
            stat_valid <= 1'b0;
            if (state == READY && state_nxt == W_OCW3)
                sel_q <= stat_sel;
            if (state == R_STAT && sub == SC)
                stat <= din;
            if (state == R_STAT && wr_last)
                stat_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/pic_bus_sequencer.md
PIC_BUS_SEQUENCER -- requirements
Module: pic_bus_sequencer

Interface
REQ-001 SHALL have parameter STROBE_CYCLES, default 2, giving the active-low width of WD, RD and each INTA pulse in clocks (legal 1..7).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have ports start in 1 (init request pulse), busy out 1, init_done out 1.
REQ-005 SHALL have config inputs: cfg_ltim 1, cfg_sngl 1, cfg_ic4 1, cfg_aeoi 1, cfg_vec_base 5, cfg_icw3 8, cfg_mask 8; all sampled on the accepted start.
REQ-006 SHALL have PIC-side ports: WD out 1 (write strobe, active low), RD out 1 (active low), A0 out 1, dout out 8, dout_en out 1, din in 8, INT in 1, INTA out 1 (active low).
REQ-007 SHALL have host-side ports: eoi_req in 1, vec_valid out 1, vec out 8.

Function
REQ-008 SHALL implement states IDLE, W_ICW1, W_ICW2, W_ICW3, W_ICW4, W_OCW1, READY, ACK1, ACK_GAP, ACK2, W_EOI.
REQ-009 Each write state SHALL run SETUP (1 clk: A0, dout valid, dout_en=1, WD=1), STROBE (STROBE_CYCLES clks, WD=0), HOLD (1 clk, WD=1, dout_en=1); total STROBE_CYCLES+2 clks.
REQ-010 Bytes: ICW1={000,1,cfg_ltim,0,cfg_sngl,cfg_ic4} A0=0; ICW2={cfg_vec_base,000} A0=1; ICW3=cfg_icw3 A0=1; ICW4={000000,cfg_aeoi,1} A0=1; OCW1=cfg_mask A0=1; EOI(OCW2)=8'h20 A0=0.
REQ-011 Sequence: IDLE -start-> W_ICW1 -> W_ICW2 -> W_ICW3 only if cfg_sngl=0 -> W_ICW4 only if cfg_ic4=1 -> W_OCW1 -> READY.
REQ-012 init_done SHALL rise the clock after the OCW1 HOLD and stay high until reset or a new accepted start.
REQ-013 start SHALL be accepted only in IDLE or READY; ignored in all other states; in READY it clears init_done and restarts at W_ICW1.
REQ-014 busy SHALL be 1 in every state except IDLE and READY.
REQ-015 In READY with INT=1: ACK1 (INTA=0 STROBE_CYCLES clks), ACK_GAP (INTA=1 2 clks), ACK2 (INTA=0 STROBE_CYCLES clks); din SHALL be captured into vec on the last ACK2 clock.
REQ-016 vec_valid SHALL pulse 1 clk on the clock after ACK2 ends; return to READY same edge.
REQ-017 In READY, eoi_req=1 with cfg_aeoi latched 0 SHALL run W_EOI; with cfg_aeoi=1 eoi_req SHALL be ignored.
REQ-018 Simultaneous eoi_req (honoured) and INT in READY: W_EOI first; INT re-evaluated on return to READY.
REQ-019 eoi_req asserted outside READY SHALL be latched (single pending flag) and serviced on next READY entry before INT.
REQ-020 INT deasserting during ACK1..ACK2 SHALL NOT abort the cycle; both INTA pulses always complete.
REQ-021 dout_en SHALL be 0 and dout 8'h00 outside SETUP/STROBE/HOLD; RD SHALL stay 1 unless REQ-026 applies.
REQ-022 Never WD=0 and RD=0 or INTA=0 in the same clock.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force IDLE, WD=RD=INTA=1, A0=0, dout=8'h00, dout_en=0, busy=0, init_done=0, vec_valid=0, vec=8'h00, pending EOI cleared, substate counter 0.
REQ-024 Reset mid-write or mid-acknowledge SHALL release all strobes on that same edge; no partial cycle resumes.

Configuration
REQ-025 Macro PIC_SEQ_STATUS_READ_EN SHALL gate a status-read feature.
REQ-026 With it defined: inputs stat_req 1, stat_sel 1 (0=IRR,1=ISR), outputs stat 8, stat_valid 1; in READY stat_req writes OCW3={000010,1,stat_sel} A0=0, then RD cycle (SETUP 1, RD=0 STROBE_CYCLES, HOLD 1, A0=0) capturing din on last RD-low clock, stat_valid pulses 1 clk; priority EOI > INT > stat_req.
REQ-027 Without it: those ports absent, RD tied 1, states unchanged otherwise.

Verification
REQ-028 Reset, start, cfg_sngl=1, cfg_ic4=0, vec_base=5'h08, mask=8'hF0 -> writes 8'h12(A0=0), 8'h40, 8'hF0; init_done after 3*(STROBE_CYCLES+2)+1 clks.
REQ-029 cfg_sngl=0, cfg_ic4=1, cfg_icw3=8'h04, cfg_aeoi=1 -> five writes ICW1=8'h11, ICW2, 8'h04, 8'h03, mask.
REQ-030 READY, INT=1, din=8'h43 on ACK2 -> two INTA pulses of STROBE_CYCLES, 2-clk gap, vec=8'h43, vec_valid one clk.
REQ-031 READY, eoi_req and INT same clk, cfg_aeoi=0 -> write 8'h20 A0=0 before INTA falls.
REQ-032 rst_n=0 during ICW2 STROBE -> WD=1 next edge, IDLE, init_done=0; start then re-sends ICW1 first.
REQ-033 With PIC_SEQ_STATUS_READ_EN, stat_req stat_sel=1, din=8'h10 -> write 8'h0B, RD pulse, stat=8'h10, stat_valid one clk.
